limber_gnrl_fcs_chk: RTL and testbench



---
 rtl/limber_gnrl_eth_pkg.sv | 29 ++
 rtl/limber_gnrl_fcs_dly4.sv | 58 +++++
 rtl/limber_gnrl_fcs_chk.sv | 189 ++++++++++++++++++
 tb/tb_limber_gnrl_fcs_chk.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/limber_gnrl_eth_pkg.sv
// Shared Ethernet helpers: reflected CRC32 constants, byte-step function and
// the FCS checker FSM encoding.
package limber_gnrl_eth_pkg;

  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0] CRC32_POLY_R  = 32'hEDB8_8320;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fcs_state_e;

  // Folds one byte into the reflected CRC register, bit0 first; no final XOR.
  function automatic logic [31:0] crc32_byte_step(input logic [31:0] crc,
                                                  input logic [7:0]  data_byte);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if ((c[0] ^ data_byte[i]) == 1'b1) begin
        c = (c >> 1) ^ CRC32_POLY_R;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/limber_gnrl_fcs_dly4.sv
// Four-entry byte/sof shift line used to hold back the FCS when stripping.
// Flush empties it; flush together with push restarts it with the pushed byte.
module limber_gnrl_fcs_dly4 (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_push,
  input  logic       i_flush,
  input  logic [7:0] i_data,
  input  logic       i_sof,
  output logic       o_full,
  output logic [7:0] o_data,
  output logic       o_sof
);

  logic [3:0][7:0] data_q, data_d;
  logic [3:0]      sof_q, sof_d;
  logic [2:0]      cnt_q, cnt_d;

  // Shift on push; occupancy tracks how many entries hold live bytes.
  always_comb begin
    data_d = data_q;
    sof_d  = sof_q;
    cnt_d  = cnt_q;
    if (i_push) begin
      data_d = {data_q[2:0], i_data};
      sof_d  = {sof_q[2:0], i_sof};
      if (i_flush) begin
        cnt_d = 3'd1;
      end else if (cnt_q == 3'd4) begin
        cnt_d = 3'd4;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end else if (i_flush) begin
      cnt_d = 3'd0;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Delay line storage.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      data_q <= '0;
      sof_q  <= 4'd0;
      cnt_q  <= 3'd0;
    end else begin
      data_q <= data_d;
      sof_q  <= sof_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_full = (cnt_q == 3'd4);
  assign o_data = data_q[3];
  assign o_sof  = sof_q[3];

endmodule

// File: rtl/limber_gnrl_fcs_chk.sv
// Receive-side Ethernet FCS checker with per-frame CRC/length status.
// Define LIMBER_FCS_STRIP_EN to drop the 4 FCS bytes from the forwarded stream.
module limber_gnrl_fcs_chk #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [7:0]       i_data,
  input  logic             i_vld,
  input  logic             i_sof,
  input  logic             i_eof,
  output logic [7:0]       o_data,
  output logic             o_vld,
  output logic             o_sof,
  output logic             o_eof,
  output logic             o_frm_done,
  output logic             o_frm_ok,
  output logic             o_crc_err,
  output logic             o_len_err,
  output logic             o_abort,
  output logic [LEN_W-1:0] o_len
);
  import limber_gnrl_eth_pkg::*;

  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  fcs_state_e       state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  logic [7:0]       data_q, data_d;
  logic             vld_q, vld_d, sof_q, sof_d, eof_q, eof_d;
  logic             done_q, done_d, ok_q, ok_d, crc_err_q, crc_err_d;
  logic             len_err_q, len_err_d, abort_q, abort_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic run_s, sof_beat_s, body_beat_s, abort_beat_s, eof_beat_s;

  assign run_s        = (state_q == ST_RUN);
  assign sof_beat_s   = i_vld & i_sof;
  assign body_beat_s  = i_vld & ~i_sof & run_s;
  assign abort_beat_s = sof_beat_s & run_s;
  assign eof_beat_s   = i_vld & i_eof & (i_sof | run_s);

  // Frame FSM: a sof with eof is a complete 1-byte frame and never enters RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (sof_beat_s && !i_eof) state_d = ST_RUN;
        else                      state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (sof_beat_s)             state_d = i_eof ? ST_IDLE : ST_RUN;
        else if (i_vld && i_eof)    state_d = ST_IDLE;
        else                        state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // CRC and byte counter restart on every sof byte and hold across i_vld gaps.
  always_comb begin
    crc_d = crc_q;
    cnt_d = cnt_q;
    if (sof_beat_s) begin
      crc_d = crc32_byte_step(CRC32_INIT, i_data);
      cnt_d = LEN_W'(1);
    end else if (body_beat_s) begin
      crc_d = crc32_byte_step(crc_q, i_data);
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + LEN_W'(1);
    end else begin
      crc_d = crc_q;
      cnt_d = cnt_q;
    end
  end

  // Status strobe; an abort reports only the truncation, not CRC/length.
  always_comb begin
    done_d    = 1'b0;
    ok_d      = 1'b0;
    crc_err_d = 1'b0;
    len_err_d = 1'b0;
    abort_d   = 1'b0;
    len_d     = '0;
    if (abort_beat_s) begin
      done_d  = 1'b1;
      abort_d = 1'b1;
      len_d   = cnt_q;
    end else if (eof_beat_s) begin
      done_d    = 1'b1;
      len_d     = cnt_d;
      crc_err_d = (crc_d != CRC32_RESIDUE);
      len_err_d = (cnt_d < LEN_W'(MIN_LEN)) || (cnt_d > LEN_W'(MAX_LEN));
      ok_d      = ~crc_err_d & ~len_err_d;
    end else begin
      done_d = 1'b0;
    end
  end

`ifdef LIMBER_FCS_STRIP_EN
  logic       dly_push_s, dly_flush_s, dly_full_s, dly_sof_s, pop_s;
  logic [7:0] dly_data_s;

  // FCS bytes are never pushed at eof; the line is emptied instead.
  assign dly_push_s  = (sof_beat_s | body_beat_s) & ~i_eof;
  assign dly_flush_s = sof_beat_s | (body_beat_s & i_eof);
  assign pop_s       = body_beat_s & dly_full_s;

  limber_gnrl_fcs_dly4 u_dly4 (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (dly_push_s),
    .i_flush (dly_flush_s),
    .i_data  (i_data),
    .i_sof   (i_sof),
    .o_full  (dly_full_s),
    .o_data  (dly_data_s),
    .o_sof   (dly_sof_s)
  );

  // Forward the byte four positions back, so the eof beat releases byte L-5.
  always_comb begin
    vld_d  = pop_s;
    data_d = pop_s ? dly_data_s : 8'h00;
    sof_d  = pop_s & dly_sof_s;
    eof_d  = pop_s & i_eof;
  end
`else
  logic fwd_s;

  assign fwd_s = sof_beat_s | body_beat_s;

  // Forward every accepted byte, FCS included.
  always_comb begin
    vld_d  = fwd_s;
    data_d = fwd_s ? i_data : 8'h00;
    sof_d  = sof_beat_s;
    eof_d  = fwd_s & i_eof;
  end
`endif

  // State, CRC and all registered outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= ST_IDLE;
      crc_q     <= CRC32_INIT;
      cnt_q     <= '0;
      data_q    <= 8'h00;
      vld_q     <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      crc_err_q <= 1'b0;
      len_err_q <= 1'b0;
      abort_q   <= 1'b0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      crc_err_q <= crc_err_d;
      len_err_q <= len_err_d;
      abort_q   <= abort_d;
      len_q     <= len_d;
    end
  end

  assign o_data     = data_q;
  assign o_vld      = vld_q;
  assign o_sof      = sof_q;
  assign o_eof      = eof_q;
  assign o_frm_done = done_q;
  assign o_frm_ok   = ok_q;
  assign o_crc_err  = crc_err_q;
  assign o_len_err  = len_err_q;
  assign o_abort    = abort_q;
  assign o_len      = len_q;

endmodule

// File: tb/tb_limber_gnrl_fcs_chk.sv
// Bench for limber_gnrl_fcs_chk: two instances (default MIN_LEN and MIN_LEN=1)
// checked every cycle against a frame-level model; honours LIMBER_FCS_STRIP_EN.
module tb_limber_gnrl_fcs_chk;

  typedef logic [7:0] byte_q_t [$];
  typedef struct packed {
    logic        vld;
    logic        sof;
    logic        eof;
    logic [7:0]  data;
    logic        done;
    logic        ok;
    logic        crc_err;
    logic        len_err;
    logic        abort;
    logic [15:0] len;
  } obs_t;
  typedef obs_t obs_q_t [$];

  localparam int MAXL = 1518;

  logic       i_clk, i_rstn, i_vld, i_sof, i_eof;
  logic [7:0] i_data;
  logic [7:0] a_data, b_data;
  logic       a_vld, a_sof, a_eof, a_done, a_ok, a_crc, a_lerr, a_abort;
  logic       b_vld, b_sof, b_eof, b_done, b_ok, b_crc, b_lerr, b_abort;
  logic [15:0] a_len, b_len;

  obs_t act_a, act_b, exp_a, exp_b;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic rn_drive;
  bit   in_frame;
  byte_q_t mq;
  logic [8:0] fwd_log [$];
  obs_q_t st_a, st_b;

  limber_gnrl_fcs_chk dut_a (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_data(i_data), .i_vld(i_vld),
    .i_sof(i_sof), .i_eof(i_eof), .o_data(a_data), .o_vld(a_vld),
    .o_sof(a_sof), .o_eof(a_eof), .o_frm_done(a_done), .o_frm_ok(a_ok),
    .o_crc_err(a_crc), .o_len_err(a_lerr), .o_abort(a_abort), .o_len(a_len)
  );

  limber_gnrl_fcs_chk #(.MIN_LEN(1)) dut_b (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_data(i_data), .i_vld(i_vld),
    .i_sof(i_sof), .i_eof(i_eof), .o_data(b_data), .o_vld(b_vld),
    .o_sof(b_sof), .o_eof(b_eof), .o_frm_done(b_done), .o_frm_ok(b_ok),
    .o_crc_err(b_crc), .o_len_err(b_lerr), .o_abort(b_abort), .o_len(b_len)
  );

  assign act_a = {a_vld, a_sof, a_eof, (a_vld ? a_data : 8'h00),
                  a_done, a_ok, a_crc, a_lerr, a_abort, a_len};
  assign act_b = {b_vld, b_sof, b_eof, (b_vld ? b_data : 8'h00),
                  b_done, b_ok, b_crc, b_lerr, b_abort, b_len};

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Standard Ethernet CRC32 (init ~0, final complement) over the first n bytes.
  function automatic logic [31:0] crc32_n(input byte_q_t f, input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, f[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // A frame is good when its last 4 bytes (little-endian) equal the CRC of the rest.
  function automatic obs_t frame_status(input byte_q_t f, input int min_len);
    obs_t r;
    int   l;
    logic [31:0] fcs;
    r = '0;
    l = f.size();
    r.done = 1'b1;
    r.len  = 16'(l);
    if (l < 4) begin
      r.crc_err = 1'b1;
    end else begin
      fcs = {f[l-1], f[l-2], f[l-3], f[l-4]};
      r.crc_err = (crc32_n(f, l - 4) != fcs);
    end
    r.len_err = (l < min_len) || (l > MAXL);
    r.ok = !r.crc_err && !r.len_err;
    return r;
  endfunction

  function automatic byte_q_t mk_frame(input int l, input bit good);
    byte_q_t f;
    logic [31:0] c;
    for (int i = 0; i < l - 4; i++) f.push_back(8'($urandom_range(0, 255)));
    if (l >= 4) begin
      c = crc32_n(f, l - 4);
      f.push_back(c[7:0]);
      f.push_back(c[15:8]);
      f.push_back(c[23:16]);
      f.push_back(c[31:24]);
      if (!good) f[l-1] = f[l-1] ^ 8'h01;
    end else begin
      for (int i = 0; i < l; i++) f.push_back(8'($urandom_range(0, 255)));
    end
    return f;
  endfunction

  function automatic obs_t nth(input obs_q_t q, input int i);
    if (i < q.size()) return q[i];
    return '0;
  endfunction

  function automatic logic [31:0] stat(input obs_t o);
    return {11'h0, o.ok, o.crc_err, o.len_err, o.abort, o.done, o.len};
  endfunction

  function automatic logic [31:0] mk_stat(input bit ok, input bit ce, input bit le,
                                          input bit ab, input int len);
    return {11'h0, ok, ce, le, ab, 1'b1, 16'(len)};
  endfunction

  // Expected outputs one cycle after the beat now being driven.
  task automatic model_step(input logic v, input logic s, input logic e, input logic [7:0] d);
    obs_t fw, sa, sb;
    bit   was;
    int   k;
    fw = '0; sa = '0; sb = '0;
    if (!i_rstn) begin
      in_frame = 1'b0;
      mq.delete();
    end else if (v) begin
      if (s) begin
        was = in_frame;
        if (was) begin
          sa.done = 1'b1; sa.abort = 1'b1; sa.len = 16'(mq.size());
          sb = sa;
        end
        mq.delete();
        mq.push_back(d);
        in_frame = !e;
`ifndef LIMBER_FCS_STRIP_EN
        fw.vld = 1'b1; fw.data = d; fw.sof = 1'b1; fw.eof = e;
`endif
        if (e && !was) begin
          sa = frame_status(mq, 64);
          sb = frame_status(mq, 1);
        end
      end else if (in_frame) begin
        k = mq.size();
        mq.push_back(d);
`ifdef LIMBER_FCS_STRIP_EN
        if (k >= 4) begin
          fw.vld = 1'b1; fw.data = mq[k-4]; fw.sof = (k == 4); fw.eof = e;
        end
`else
        fw.vld = 1'b1; fw.data = d; fw.eof = e;
`endif
        if (e) begin
          sa = frame_status(mq, 64);
          sb = frame_status(mq, 1);
          in_frame = 1'b0;
        end
      end
    end
    exp_a = sa | fw;
    exp_b = sb | fw;
  endtask

  // One cycle: compare outputs at the falling edge, then drive the next beat.
  task automatic beat(input logic v, input logic s, input logic e, input logic [7:0] d);
    @(negedge i_clk);
    check("out_a", act_a, exp_a);
    check("out_b", act_b, exp_b);
    if (act_a.vld) fwd_log.push_back({act_a.eof, act_a.data});
    if (act_a.done) st_a.push_back(act_a);
    if (act_b.done) st_b.push_back(act_b);
    i_rstn = rn_drive;
    i_vld = v; i_sof = s; i_eof = e; i_data = d;
    model_step(v, s, e, d);
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)));
  endtask

  task automatic send(input byte_q_t f, input int gap, input bit do_eof);
    for (int i = 0; i < f.size(); i++) begin
      if (i > 0 && gap == 1) idle(1);
      if (i > 0 && gap == 2) idle($urandom_range(0, 2));
      beat(1'b1, i == 0, do_eof && (i == f.size() - 1), f[i]);
    end
  endtask

  task automatic clear_logs();
    fwd_log.delete();
    st_a.delete();
    st_b.delete();
  endtask

  initial begin
    byte_q_t f, fa, fb;
    logic [8:0] ref_fwd [$];
    obs_q_t ref_st;
    int mism, l;
    bit prev_abort;

    i_rstn = 1'b0; rn_drive = 1'b0;
    i_vld = 1'b0; i_sof = 1'b0; i_eof = 1'b0; i_data = 8'h00;
    exp_a = '0; exp_b = '0;
    in_frame = 1'b0;
    idle(3);
    check("reset_zero", act_a, 32'h0);
    rn_drive = 1'b1;
    idle(2);

    f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("crc_123456789", crc32_n(f, 9), 32'hCBF4_3926);

    // Good 13-byte frame: "123456789" + FCS
    f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
          8'h26, 8'h39, 8'hF4, 8'hCB};
    clear_logs();
    send(f, 0, 1'b1);
    idle(2);
    check("short_b_status", stat(nth(st_b, 0)), mk_stat(1, 0, 0, 0, 13));
    check("short_a_status", stat(nth(st_a, 0)), mk_stat(0, 0, 1, 0, 13));
`ifdef LIMBER_FCS_STRIP_EN
    check("short_fwd_cnt", 32'(fwd_log.size()), 32'd9);
    check("short_fwd_last", (fwd_log.size() > 0) ? 32'(fwd_log[$]) : 32'h0, {23'h0, 9'h139});
`else
    check("short_fwd_cnt", 32'(fwd_log.size()), 32'd13);
    check("short_fwd_last", (fwd_log.size() > 0) ? 32'(fwd_log[$]) : 32'h0, {23'h0, 9'h1CB});
`endif

    // Corrupt last FCS byte
    f[12] = 8'hCA;
    clear_logs();
    send(f, 0, 1'b1);
    idle(2);
    check("corrupt_b_status", stat(nth(st_b, 0)), mk_stat(0, 1, 0, 0, 13));

    // Length boundaries, back to back
    clear_logs();
    send(mk_frame(60, 1), 0, 1'b1);
    send(mk_frame(1519, 1), 0, 1'b1);
    send(mk_frame(64, 1), 0, 1'b1);
    send(mk_frame(1518, 1), 0, 1'b1);
    idle(2);
    check("len60",   stat(nth(st_a, 0)), mk_stat(0, 0, 1, 0, 60));
    check("len1519", stat(nth(st_a, 1)), mk_stat(0, 0, 1, 0, 1519));
    check("len64",   stat(nth(st_a, 2)), mk_stat(1, 0, 0, 0, 64));
    check("len1518", stat(nth(st_a, 3)), mk_stat(1, 0, 0, 0, 1518));

    // Abort after 20 bytes, then a good 64-byte frame
    clear_logs();
    send(mk_frame(30, 1)[0:19], 0, 1'b0);
    send(mk_frame(64, 1), 0, 1'b1);
    idle(2);
    check("abort_status", stat(nth(st_a, 0)), mk_stat(0, 0, 0, 1, 20));
    check("after_abort",  stat(nth(st_a, 1)), mk_stat(1, 0, 0, 0, 64));

    // Flow gaps must not change status or forwarded data
    fa = mk_frame(64, 1);
    fb = mk_frame(70, 1);
    clear_logs();
    send(fa, 0, 1'b1);
    send(fb, 0, 1'b1);
    idle(2);
    ref_fwd = fwd_log;
    ref_st  = st_a;
    clear_logs();
    send(fa, 1, 1'b1);
    send(fb, 1, 1'b1);
    idle(2);
    check("gap_st_cnt", 32'(st_a.size()), 32'(ref_st.size()));
    check("gap_st0", stat(nth(st_a, 0)), stat(nth(ref_st, 0)));
    check("gap_st1", stat(nth(st_a, 1)), stat(nth(ref_st, 1)));
    check("gap_fwd_cnt", 32'(fwd_log.size()), 32'(ref_fwd.size()));
    mism = 0;
    for (int i = 0; i < fwd_log.size() && i < ref_fwd.size(); i++)
      if (fwd_log[i] !== ref_fwd[i]) mism++;
    check("gap_fwd_data", 32'(mism), 32'd0);

    // Reset in the middle of a 100-byte frame
    clear_logs();
    f = mk_frame(100, 1);
    send(f[0:29], 0, 1'b0);
    rn_drive = 1'b0;
    idle(1);
    rn_drive = 1'b1;
    idle(1);
    check("rst_mid_zero", act_a, 32'h0);
    idle(2);
    check("rst_no_done", 32'(st_a.size()), 32'd0);
    send(mk_frame(64, 1), 0, 1'b1);
    idle(2);
    check("rst_next_ok", stat(nth(st_a, 0)), mk_stat(1, 0, 0, 0, 64));

    // Randomized frames, gaps, corruption, aborts and stray bytes
    prev_abort = 1'b0;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: l = $urandom_range(1, 8);
        1: l = $urandom_range(60, 68);
        default: l = $urandom_range(1, 200);
      endcase
      if (prev_abort && l < 2) l = 2;
      prev_abort = ($urandom_range(0, 9) == 0);
      send(mk_frame(l, $urandom_range(0, 3) != 0), $urandom_range(0, 2), !prev_abort);
      if (!prev_abort) begin
        if ($urandom_range(0, 3) == 0)
          beat(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        idle($urandom_range(0, 2));
      end
    end
    send(mk_frame(64, 1), 0, 1'b1);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
